// File: rtl/byte_encode_pkg.sv
// Shared constants and bit-ordering helper for polynomial byte encode/decode.
// N       : coefficients per polynomial
// Q       : coefficient modulus (inputs are assumed already reduced)
// D_MAX   : widest legal coefficient field
// enc_bit_pos : position of coefficient bit j of coefficient i in the packed
//               little-endian bit string; encode and decode both use it so
//               they cannot drift apart.
package byte_encode_pkg;

  localparam int N     = 256;
  localparam int Q     = 3329;
  localparam int D_MAX = 12;

  function automatic int enc_bit_pos(input int i, input int j, input int d);
    return i * d + j;
  endfunction

endpackage

// File: rtl/byte_encode.sv
// Packs 256 coefficients of D bits each into a 32*D-byte little-endian array.
// Packing is pure wiring; one register stage drives the outputs.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (clears valid_o and b_o)
//   valid_i : f_i holds a polynomial this cycle
//   f_i     : 256 coefficients, f_i[i] is coefficient i
//   valid_o : b_o holds an encoding
//   b_o     : packed byte array, b_o[k] is byte k
module byte_encode
  import byte_encode_pkg::*;
#(
  parameter int D        = 12,
  parameter int IN_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic [N-1:0][IN_WIDTH-1:0]   f_i,
  output logic                         valid_o,
  output logic [32*D-1:0][7:0]         b_o
);

  if (D < 1 || D > D_MAX) begin : g_bad_d
    $error("byte_encode: D=%0d outside 1..%0d", D, D_MAX);
  end
  if (IN_WIDTH < D) begin : g_bad_w
    $error("byte_encode: IN_WIDTH=%0d smaller than D=%0d", IN_WIDTH, D);
  end

  logic [N*D-1:0]      w_bits;
  logic [32*D-1:0][7:0] w_bytes;
  // Coefficient bits above D are dropped on purpose; folded here only so they
  // have a reader.
  logic [N-1:0]        w_unused_hi;

  for (genvar i = 0; i < N; i++) begin : g_coef
    for (genvar j = 0; j < D; j++) begin : g_bit
      localparam int P = enc_bit_pos(i, j, D);
      assign w_bits[P] = f_i[i][j];
    end
    if (IN_WIDTH > D) begin : g_hi
      assign w_unused_hi[i] = ^f_i[i][IN_WIDTH-1:D];
    end else begin : g_no_hi
      assign w_unused_hi[i] = 1'b0;
    end
  end

  // Byte k is bits [8k+7:8k] of the string: a straight reinterpretation.
  assign w_bytes = w_bits;

  logic                 r_valid;
  logic [32*D-1:0][7:0] r_bytes;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_bytes <= '0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_bytes <= w_bytes;
      end
    end
  end

  assign valid_o = r_valid;
  assign b_o     = r_bytes;

endmodule

// File: tb/tb_byte_encode.sv
// Self-checking bench: three encoders (D = 1, 8, 12) share clock, reset and
// valid; expectations come from a bit-serial model through a scoreboard queue.
module tb_byte_encode;
  import byte_encode_pkg::*;

  localparam int W = 3072;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid = 1'b0;
  logic [255:0][15:0] f1, f8, f12;
  logic v1, v8, v12;
  logic [31:0][7:0]  b1;
  logic [255:0][7:0] b8;
  logic [383:0][7:0] b12;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  byte_encode #(.D(1), .IN_WIDTH(16)) u_d1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .f_i(f1), .valid_o(v1), .b_o(b1));
  byte_encode #(.D(8), .IN_WIDTH(16)) u_d8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .f_i(f8), .valid_o(v8), .b_o(b8));
  byte_encode #(.D(12), .IN_WIDTH(16)) u_d12 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .f_i(f12), .valid_o(v12), .b_o(b12));

  typedef struct {
    logic         v;
    logic [W-1:0] e1;
    logic [W-1:0] e8;
    logic [W-1:0] e12;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] held1 = '0, held8 = '0, held12 = '0;

  // Bit-serial reference: walk coefficient bits in order, dropping each into
  // the next free bit of the byte stream.
  function automatic logic [383:0][7:0] model(input logic [255:0][15:0] f, input int d);
    logic [383:0][7:0] r;
    int p;
    r = '0;
    p = 0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < d; j++) begin
        r[p / 8][p % 8] = f[i][j];
        p++;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    int k;
    checks++;
    assert (obs === exp) else begin
      failures++;
      k = 0;
      for (int n = 383; n >= 0; n--) if (obs[n*8 +: 8] !== exp[n*8 +: 8]) k = n;
      $error("FAIL %s byte=%0d observed=%h expected=%h", tag, k, obs[k*8 +: 8], exp[k*8 +: 8]);
    end
  endtask

  task automatic drive(input logic r, input logic v);
    exp_t e;
    rst = r;
    valid = v;
    if (r) begin
      e.v = 1'b0; e.e1 = '0; e.e8 = '0; e.e12 = '0;
    end else if (v) begin
      e.v = 1'b1;
      e.e1 = W'(model(f1, 1));
      e.e8 = W'(model(f8, 8));
      e.e12 = W'(model(f12, 12));
    end else begin
      e.v = 1'b0; e.e1 = held1; e.e8 = held8; e.e12 = held12;
    end
    held1 = e.e1; held8 = e.e8; held12 = e.e12;
    sb.push_back(e);
  endtask

  task automatic step_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_v1"},  W'(v1),  W'(e.v));
      chk({tag, "_v8"},  W'(v8),  W'(e.v));
      chk({tag, "_v12"}, W'(v12), W'(e.v));
      chk({tag, "_b1"},  W'(b1),  e.e1);
      chk({tag, "_b8"},  W'(b8),  e.e8);
      chk({tag, "_b12"}, W'(b12), e.e12);
    end
  endtask

  task automatic randomize_inputs(input logic keep_low12);
    for (int i = 0; i < 256; i++) begin
      f1[i]  = 16'($urandom);
      f8[i]  = 16'($urandom);
      f12[i] = 16'($urandom);
      if (keep_low12) f12[i][11:0] = 12'($urandom_range(Q - 1, 0));
    end
  endtask

  initial begin
    logic [W-1:0] x;
    for (int i = 0; i < 256; i++) begin
      f1[i] = 16'(i % 2);
      f8[i] = 16'(i);
      f12[i] = 16'(i % Q);
    end

    // reset wins over a simultaneous valid
    @(posedge clk); #1;
    drive(1'b1, 1'b1);
    step_check("reset");
    drive(1'b0, 1'b0);
    step_check("idle_after_reset");

    // directed patterns
    drive(1'b0, 1'b1);
    step_check("pattern");
    x = '0;
    for (int k = 0; k < 32; k++) x[k*8 +: 8] = 8'hAA;
    chk("d1_all_aa", W'(b1), x);
    x = '0;
    for (int k = 0; k < 256; k++) x[k*8 +: 8] = 8'(k);
    chk("d8_identity", W'(b8), x);
    chk("d12_first6", W'(b12[5:0]), W'(48'h00_30_02_00_10_00));

    // back-to-back distinct polynomials, upper input bits set
    randomize_inputs(1'b1);
    f8[0] = 16'h01FF;
    drive(1'b0, 1'b1);
    step_check("b2b_0");
    chk("d8_upper_ignored", W'(b8[0]), W'(8'hFF));
    randomize_inputs(1'b1);
    drive(1'b0, 1'b1);
    step_check("b2b_1");
    randomize_inputs(1'b1);
    drive(1'b0, 1'b1);
    step_check("b2b_2");

    // idle cycles hold the last encoding while inputs wander
    randomize_inputs(1'b1);
    drive(1'b0, 1'b0);
    step_check("hold_0");
    randomize_inputs(1'b1);
    drive(1'b0, 1'b0);
    step_check("hold_1");

    // mid-stream reset with valid, then resume
    randomize_inputs(1'b1);
    drive(1'b0, 1'b1);
    step_check("pre_reset");
    randomize_inputs(1'b1);
    drive(1'b1, 1'b1);
    step_check("mid_reset");
    randomize_inputs(1'b1);
    drive(1'b0, 1'b1);
    step_check("resume");
    drive(1'b0, 1'b0);
    step_check("resume_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_encode.md
BYTE_ENCODE -- requirements
Module: byte_encode

Interface
REQ-001 Parameter D, default 12: bits per coefficient; legal range 1..12; elaboration SHALL fail outside this range.
REQ-002 Parameter IN_WIDTH, default 16: width of each input coefficient; elaboration SHALL fail if IN_WIDTH < D.
REQ-003 clk_i  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1: reset, synchronous and active-high.
REQ-005 valid_i  input  1: f_i holds a valid polynomial this cycle.
REQ-006 f_i  input  [255:0][IN_WIDTH-1:0]: 256 coefficients, f_i[i] is coefficient i.
REQ-007 valid_o  output  1: b_o holds an encoding.
REQ-008 b_o  output  [32*D-1:0][7:0]: packed byte array, b_o[k] is byte k.

Function
REQ-009 The block SHALL form a 256*D-bit little-endian bit string in which bit (i*D + j) equals f_i[i][j], for i = 0..255 and j = 0..D-1.
REQ-010 Byte k of the result SHALL be bits [8k+7 : 8k] of that string, for k = 0..32*D-1; bit 0 of each byte is the lowest-numbered string bit.
REQ-011 Coefficient bits at positions D..IN_WIDTH-1 SHALL be ignored; no modular reduction is performed.
REQ-012 For D = 12, the caller SHALL supply coefficients below q = 3329; the block SHALL NOT check this.
REQ-013 The packing SHALL be pure wiring (no arithmetic), followed by one output register stage.
REQ-014 Latency SHALL be exactly 1 cycle: when valid_i = 1 at edge N, b_o SHALL show the encoding of f_i sampled at edge N, and valid_o SHALL be 1 after that edge.
REQ-015 When valid_i = 0 at an edge, valid_o SHALL go to 0 and b_o SHALL hold its previous value.
REQ-016 Back-to-back valid_i SHALL be accepted every cycle with no stall; there is no backpressure input.

Reset
REQ-017 When rst_i = 1 at a rising edge, valid_o SHALL be 0 and b_o SHALL be all zeros after that edge, regardless of valid_i.
REQ-018 Reset SHALL take priority over a simultaneous valid_i.
REQ-019 The first encoding SHALL be captured at the first edge with rst_i = 0 and valid_i = 1.

Structure
REQ-020 The shared package SHALL hold the constants N = 256 (coefficients per polynomial) and Q = 3329; the block SHALL import them.
REQ-021 The block SHALL be a single module with generate loops over i and j, with no sub-module.
REQ-022 The inverse operation (byte decode) SHALL reuse the same bit-ordering definition from REQ-009 and REQ-010.

Verification
REQ-023 D=1, f_i[i] = i%2, valid_i = 1 -> after 1 cycle, every byte of b_o = 0xAA and valid_o = 1.
REQ-024 D=8, f_i[i] = i -> b_o[k] = k for k = 0..255; also f_i[0] = 0x1FF -> b_o[0] = 0xFF (upper bits ignored).
REQ-025 D=12, f_i[i] = i%3329 -> b_o[0..5] = 0x00, 0x10, 0x00, 0x02, 0x30, 0x00; the full array SHALL match a bit-serial reference model.
REQ-026 Apply valid_i pulses on consecutive cycles with different polynomials -> each encoding appears exactly 1 cycle later, in order; valid_i = 0 -> valid_o = 0 and b_o held.
REQ-027 Assert rst_i = 1 together with valid_i = 1 mid-stream -> b_o = 0 and valid_o = 0 after that edge; normal operation resumes on the next valid_i.
